// File: rtl/fp16_pkg.sv
// Shared definitions for the FP16 subtract-normalize path: FSM states and
// format constants.
package fp16_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int          EXP_W    = 5;
  localparam int          FRAC_W   = 10;
  localparam int          MANT_W   = 14;
  localparam int          EXP_BIAS = 15;
  localparam logic [4:0]  EXP_MAX  = 5'h1F;
  localparam logic [15:0] QNAN     = 16'h7E00;

endpackage

// File: rtl/fp16_round_rne.sv
// Round-to-nearest-even on a 10-bit fraction with guard/round/sticky bits.
// Carry out of the fraction bumps the exponent; exponent 31 becomes infinity.
module fp16_round_rne
  import fp16_pkg::*;
(
  input  logic [FRAC_W-1:0] frac,
  input  logic              guard,
  input  logic              rnd,
  input  logic              sticky,
  input  logic [EXP_W-1:0]  exp_field,
  output logic [FRAC_W-1:0] frac_rnd,
  output logic [EXP_W-1:0]  exp_rnd
);

  logic              inc;
  logic [FRAC_W:0]   sum;

  always_comb begin
    inc      = guard & (rnd | sticky | frac[0]);
    sum      = {1'b0, frac} + {{FRAC_W{1'b0}}, inc};
    frac_rnd = sum[FRAC_W-1:0];
    exp_rnd  = exp_field;
    // A subnormal carrying into bit 10 becomes the smallest normal (0 -> 1).
    if (sum[FRAC_W]) begin
      frac_rnd = '0;
      if (exp_field != EXP_MAX) exp_rnd = exp_field + 5'd1;
    end
    if (exp_rnd == EXP_MAX) frac_rnd = '0;
  end

endmodule

// File: rtl/fp16_sub_normalize.sv
// Multi-cycle normalizer for an FP16 magnitude difference: shifts left one bit
// per cycle until the integer bit is set or the exponent floor is hit, then rounds.
module fp16_sub_normalize
  import fp16_pkg::*;
(
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic        EXC_IN,
  input  logic [15:0] EXC_Q,
  input  logic        SIGN_IN,
  input  logic [4:0]  EXP_IN,
  input  logic [13:0] DIFF_MANT,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic [15:0] Q,
  output logic        EXC
);

  state_t              state;
  logic [3:0]          shift_cnt;
  logic [MANT_W-1:0]   mant;
  logic [EXP_W-1:0]    exp_w;
  logic                sign;
  logic                shift_more;
  logic [FRAC_W-1:0]   frac_rnd;
  logic [EXP_W-1:0]    exp_rnd;

  assign shift_more = !mant[MANT_W-1] && (exp_w > 5'd1) && (shift_cnt != 4'd13);

  fp16_round_rne u_round (
    .frac      (mant[12:3]),
    .guard     (mant[2]),
    .rnd       (mant[1]),
    .sticky    (mant[0]),
    .exp_field (exp_w),
    .frac_rnd  (frac_rnd),
    .exp_rnd   (exp_rnd)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= IDLE;
      IN_READY  <= 1'b1;
      OUT_VALID <= 1'b0;
      Q         <= 16'h0000;
      EXC       <= 1'b0;
      shift_cnt <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (IN_VALID) begin
            IN_READY  <= 1'b0;
            shift_cnt <= 4'd0;
            if (EXC_IN) begin
              state     <= DONE;
              OUT_VALID <= 1'b1;
              Q         <= EXC_Q;
              EXC       <= 1'b1;
            end else if (DIFF_MANT == '0) begin
              // Exact cancellation always yields +0 under RNE.
              state     <= DONE;
              OUT_VALID <= 1'b1;
              Q         <= 16'h0000;
              EXC       <= 1'b0;
            end else begin
              state <= SHIFT;
              EXC   <= 1'b0;
            end
          end
        end
        SHIFT: begin
          if (shift_more) shift_cnt <= shift_cnt + 4'd1;
          else            state     <= ROUND;
        end
        ROUND: begin
          Q         <= {sign, exp_rnd, frac_rnd};
          EXC       <= 1'b0;
          OUT_VALID <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (OUT_READY) begin
            state     <= IDLE;
            OUT_VALID <= 1'b0;
            IN_READY  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Datapath registers carry no reset; they are always loaded on accept.
  always_ff @(posedge CLK) begin
    if (state == IDLE && IN_VALID) begin
      mant  <= DIFF_MANT;
      exp_w <= (EXP_IN == 5'd0) ? 5'd1 : EXP_IN;
      sign  <= SIGN_IN;
    end else if (state == SHIFT) begin
      if (shift_more) begin
        mant  <= {mant[MANT_W-2:0], mant[0]};
        exp_w <= exp_w - 5'd1;
      end else if (!mant[MANT_W-1]) begin
        exp_w <= 5'd0;
      end
    end
  end

endmodule

// File: tb/tb_fp16_sub_normalize.sv
// Directed bench for fp16_sub_normalize against a closed-form FP16 normalize/round model.
module tb_fp16_sub_normalize;

  logic        CLK;
  logic        RST_N;
  logic        IN_VALID;
  logic        IN_READY;
  logic        EXC_IN;
  logic [15:0] EXC_Q;
  logic        SIGN_IN;
  logic [4:0]  EXP_IN;
  logic [13:0] DIFF_MANT;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [15:0] Q;
  logic        EXC;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_q   = 16'h0000;
  logic        exp_exc = 1'b0;

  fp16_sub_normalize dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .EXC_IN    (EXC_IN),
    .EXC_Q     (EXC_Q),
    .SIGN_IN   (SIGN_IN),
    .EXP_IN    (EXP_IN),
    .DIFF_MANT (DIFF_MANT),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .Q         (Q),
    .EXC       (EXC)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Result from value semantics: find the leading one, shift it to bit 13 but
  // never below exponent 1, then RNE on the bits below the 10-bit fraction.
  function automatic logic [15:0] model(input logic exc, input logic [15:0] excq,
                                        input logic sign, input logic [4:0] e_in,
                                        input logic [13:0] d, output int lat);
    int e, p, k, field, q, rem;
    logic [13:0] sh;
    if (exc) begin lat = 1; return excq; end
    if (d == 14'd0) begin lat = 1; return 16'h0000; end
    e = (e_in == 5'd0) ? 1 : int'(e_in);
    p = 0;
    for (int i = 0; i < 14; i++) if (d[i]) p = i;
    k = 13 - p;
    if (k > e - 1) k = e - 1;
    sh = d << k;
    if (d[0]) sh = sh | 14'((1 << k) - 1);
    field = sh[13] ? (e - k) : 0;
    q = field * 1024 + int'(sh[12:3]);
    rem = int'(sh[2:0]);
    if (rem > 4 || (rem == 4 && sh[3])) q++;
    if (q >= 31 * 1024) q = 31 * 1024;
    lat = 3 + k;
    return {sign, q[14:0]};
  endfunction

  always @(negedge CLK) begin
    if (RST_N && OUT_VALID) begin
      chk("mon_q", 32'(Q), 32'(exp_q));
      chk("mon_exc", 32'(EXC), 32'(exp_exc));
      chk("mon_in_ready", 32'(IN_READY), 32'd0);
    end
  end

  task automatic wait_ready();
    int cyc = 0;
    while (!IN_READY && cyc < 50) begin @(negedge CLK); cyc++; end
    chk("ready_timeout", 32'(IN_READY), 32'd1);
  endtask

  task automatic run(input logic exc, input logic [15:0] excq, input logic sign,
                     input logic [4:0] e, input logic [13:0] d, input int hold,
                     input logic pin, input logic [15:0] lit_q, input int lit_lat);
    int lat_m, cyc;
    logic [15:0] qm;
    qm = model(exc, excq, sign, e, d, lat_m);
    if (pin) begin
      chk("model_q_literal", 32'(qm), 32'(lit_q));
      chk("model_lat_literal", 32'(lat_m), 32'(lit_lat));
    end
    wait_ready();
    exp_q = qm; exp_exc = exc;
    EXC_IN = exc; EXC_Q = excq; SIGN_IN = sign; EXP_IN = e; DIFF_MANT = d;
    IN_VALID = 1'b1;
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    cyc = 1;
    while (!OUT_VALID && cyc < 40) begin @(posedge CLK); #1; cyc++; end
    chk("out_valid_timeout", 32'(OUT_VALID), 32'd1);
    chk("latency", 32'(cyc), 32'(lat_m));
    if (pin) begin
      chk("q_literal", 32'(Q), 32'(lit_q));
      chk("lat_literal", 32'(cyc), 32'(lit_lat));
    end
    repeat (hold) @(posedge CLK);
    #1;
    OUT_READY = 1'b1;
    @(posedge CLK); #1;
    OUT_READY = 1'b0;
    chk("release_valid", 32'(OUT_VALID), 32'd0);
    chk("release_ready", 32'(IN_READY), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    logic [13:0] rd;
    RST_N = 1'b0; IN_VALID = 1'b0; EXC_IN = 1'b0; EXC_Q = 16'h0; SIGN_IN = 1'b0;
    EXP_IN = 5'd0; DIFF_MANT = 14'd0; OUT_READY = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_q", 32'(Q), 32'd0);
    chk("rst_exc", 32'(EXC), 32'd0);
    chk("rst_out_valid", 32'(OUT_VALID), 32'd0);
    chk("rst_in_ready", 32'(IN_READY), 32'd1);
    @(negedge CLK) RST_N = 1'b1;
    @(posedge CLK); #1;

    //   exc   excq      sg    exp    diff       hold pin lit_q     lat
    run(1'b1, 16'h7E00, 1'b0, 5'd15, 14'h0000, 0, 1'b1, 16'h7E00, 1);
    run(1'b0, 16'h0000, 1'b0, 5'd15, 14'h2000, 0, 1'b1, 16'h3C00, 3);
    run(1'b0, 16'h0000, 1'b0, 5'd15, 14'h0400, 1, 1'b1, 16'h3000, 6);
    run(1'b0, 16'h0000, 1'b0, 5'd15, 14'h3FFC, 0, 1'b1, 16'h4000, 3);
    run(1'b0, 16'h0000, 1'b0, 5'd1,  14'h1000, 0, 1'b1, 16'h0200, 3);
    run(1'b0, 16'h0000, 1'b1, 5'd9,  14'h0000, 5, 1'b1, 16'h0000, 1);
    run(1'b0, 16'h0000, 1'b0, 5'd30, 14'h3FFC, 0, 1'b1, 16'h7C00, 3);
    run(1'b0, 16'h0000, 1'b0, 5'd0,  14'h1000, 0, 1'b1, 16'h0200, 3);
    run(1'b0, 16'h0000, 1'b1, 5'd2,  14'h0800, 2, 1'b1, 16'h8200, 4);
    run(1'b0, 16'h0000, 1'b0, 5'd15, 14'h2004, 0, 1'b1, 16'h3C00, 3);
    run(1'b0, 16'h0000, 1'b0, 5'd15, 14'h200C, 0, 1'b1, 16'h3C02, 3);
    run(1'b0, 16'h0000, 1'b0, 5'd15, 14'h2005, 0, 1'b1, 16'h3C01, 3);
    run(1'b0, 16'h0000, 1'b0, 5'd15, 14'h0001, 0, 1'b1, 16'h0C00, 16);
    run(1'b0, 16'h0000, 1'b0, 5'd1,  14'h1FFC, 0, 1'b1, 16'h0400, 3);

    // DONE with OUT_READY and IN_VALID together must only return to IDLE.
    wait_ready();
    exp_q = 16'h0000; exp_exc = 1'b0;
    EXC_IN = 1'b0; SIGN_IN = 1'b0; EXP_IN = 5'd15; DIFF_MANT = 14'h0000;
    IN_VALID = 1'b1;
    @(posedge CLK); #1;
    chk("b2b_first_valid", 32'(OUT_VALID), 32'd1);
    DIFF_MANT = 14'h2000;
    OUT_READY = 1'b1;
    @(posedge CLK); #1;
    OUT_READY = 1'b0;
    chk("b2b_no_accept_valid", 32'(OUT_VALID), 32'd0);
    chk("b2b_no_accept_ready", 32'(IN_READY), 32'd1);
    exp_q = 16'h3C00;
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    chk("b2b_accept_ready", 32'(IN_READY), 32'd0);
    begin
      int cyc = 1;
      while (!OUT_VALID && cyc < 40) begin @(posedge CLK); #1; cyc++; end
      chk("b2b_latency", 32'(cyc), 32'd3);
      chk("b2b_q", 32'(Q), 32'h3C00);
    end
    OUT_READY = 1'b1;
    @(posedge CLK); #1;
    OUT_READY = 1'b0;

    // Reset in the middle of a long SHIFT sequence.
    wait_ready();
    exp_q = 16'h0C00; exp_exc = 1'b0;
    EXP_IN = 5'd15; DIFF_MANT = 14'h0001; IN_VALID = 1'b1;
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("midshift_valid", 32'(OUT_VALID), 32'd0);
    RST_N = 1'b0;
    #1;
    chk("async_rst_ready", 32'(IN_READY), 32'd1);
    chk("async_rst_q", 32'(Q), 32'd0);
    chk("async_rst_valid", 32'(OUT_VALID), 32'd0);
    @(negedge CLK) RST_N = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      chk("post_rst_valid", 32'(OUT_VALID), 32'd0);
      chk("post_rst_ready", 32'(IN_READY), 32'd1);
    end
    run(1'b0, 16'h0000, 1'b1, 5'd15, 14'h0400, 0, 1'b1, 16'hB000, 6);

    for (int n = 0; n < 30; n++) begin
      rd = 14'($urandom_range(0, 16383) >> $urandom_range(0, 13));
      run(($urandom_range(0, 7) == 0), 16'($urandom), 1'($urandom),
          5'($urandom_range(0, 30)), rd, $urandom_range(0, 2), 1'b0, 16'h0000, 0);
    end

    lat = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp16_sub_normalize.md
FP16_SUB_NORMALIZE -- requirements
Module: fp16_sub_normalize

Interface
REQ-001 SHALL have port CLK  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port RST_N  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port IN_VALID  input  1  upstream transaction present.
REQ-004 SHALL have port IN_READY  output  1  block can accept; high only in IDLE.
REQ-005 SHALL have port EXC_IN  input  1  special-case flag from the FP16 special-case stage.
REQ-006 SHALL have port EXC_Q  input  16  special-case result word.
REQ-007 SHALL have port SIGN_IN  input  1  sign of the magnitude difference.
REQ-008 SHALL have port EXP_IN  input  5  biased exponent of the larger operand (0 treated as 1).
REQ-009 SHALL have port DIFF_MANT  input  14  aligned, non-negative magnitude difference: [13] integer, [12:3] fraction, [2] guard, [1] round, [0] sticky.
REQ-010 SHALL have port OUT_VALID  output  1  result valid.
REQ-011 SHALL have port OUT_READY  input  1  downstream accepts.
REQ-012 SHALL have port Q  output  16  FP16 result, registered.
REQ-013 SHALL have port EXC  output  1  registered copy of EXC_IN for the transaction.

Function
REQ-014 SHALL implement FSM states IDLE, SHIFT, ROUND, DONE.
REQ-015 Accept SHALL occur on a rising edge with state IDLE and IN_VALID=1; all inputs are captured then.
REQ-016 On accept with EXC_IN=1: next state DONE, Q=EXC_Q, EXC=1 (latency 1 cycle).
REQ-017 On accept with EXC_IN=0 and DIFF_MANT=0: next state DONE, Q=16'h0000 (+0, RNE rule), EXC=0 (latency 1).
REQ-018 Otherwise next state SHIFT; working exponent = max(EXP_IN,1).
REQ-019 In SHIFT, each cycle with mant[13]=0 and exp>1: mant shifts left 1 (sticky bit stays in [0]), exp decrements by 1.
REQ-020 In SHIFT, when mant[13]=1 or exp=1: next state ROUND; exponent field = exp if mant[13]=1, else 0 (subnormal).
REQ-021 A 4-bit shift counter SHALL force transition to ROUND after 13 shifts.
REQ-022 ROUND SHALL apply round-to-nearest-even: increment fraction iff G & (R | S | LSB).
REQ-023 Fraction overflow SHALL set fraction 0 and increment exponent field (subnormal 0 -> 1); exponent reaching 31 SHALL yield infinity (fraction 0).
REQ-024 ROUND -> DONE; normal-path latency = 3 + number of shifts.
REQ-025 In DONE, OUT_VALID=1 and Q/EXC SHALL be held stable until OUT_READY=1; then next state IDLE.
REQ-026 OUT_READY=1 and IN_VALID=1 in the same DONE cycle SHALL not accept; accept occurs in IDLE only (no back-to-back bypass).

Reset
REQ-027 RST_N=0 SHALL immediately force IDLE, Q=16'h0000, EXC=0, OUT_VALID=0, shift counter 0; IN_READY=1 after release.
REQ-028 Reset during SHIFT/ROUND/DONE SHALL discard the in-flight transaction with no output.

Structure
REQ-029 Shared package fp16_pkg SHALL hold FSM state typedef, EXP_MAX=5'h1F, EXP_BIAS=15, QNAN=16'h7E00, mantissa widths.
REQ-030 Rounding logic SHALL be one combinational sub-module fp16_round_rne (fraction, G, R, S, exponent in -> rounded fraction and exponent out).

Verification
REQ-031 EXC_IN=1, EXC_Q=16'h7E00 -> Q=16'h7E00, EXC=1, OUT_VALID 1 cycle after accept.
REQ-032 EXP_IN=15, DIFF_MANT=14'h2000 -> Q=16'h3C00, 0 shifts, OUT_VALID 3 cycles after accept; EXP_IN=15, DIFF_MANT=14'h0400 -> Q=16'h3000, 6 cycles.
REQ-033 EXP_IN=15, DIFF_MANT=14'h3FFC -> round carry, Q=16'h4000.
REQ-034 EXP_IN=1, DIFF_MANT=14'h1000 -> subnormal Q=16'h0200, 3 cycles.
REQ-035 DIFF_MANT=0, SIGN_IN=1 -> Q=16'h0000 after 1 cycle; OUT_READY=0 for 5 cycles -> Q stable, IN_READY=0 throughout.
REQ-036 RST_N low mid-SHIFT -> OUT_VALID stays 0, IN_READY=1 after release, next transaction correct.
